// File: rtl/fpu_32_reciprocal.sv
// Single-cycle IEEE-754 binary32 reciprocal.
// The long division, rounding and special-case decode are all combinational.
// Results are registered, so one operand can be accepted every cycle.
// Zero and subnormal inputs are treated as zero.
// Results that would be subnormal are flushed to signed zero.
module fpu_32_reciprocal #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             div_by_zero
);

  logic        sgn;
  logic [7:0]  exp_in;
  logic [22:0] frac;
  logic [23:0] mant;

  assign sgn    = in[31];
  assign exp_in = in[30:23];
  assign frac   = in[22:0];
  assign mant   = {1'b1, frac};

  // Restoring division of 2^48 by the 24-bit mantissa.
  // The remainder starts at 2^23, which is below the mantissa whenever the
  // fraction is non-zero. That leaves 25 quotient bits in [2^24, 2^25):
  // bit 24 is the hidden one, bits 23..1 are the fraction and bit 0 is guard.
  logic [24:0] quo;
  logic [25:0] rem;

  // Unrolled long division; the remainder left over feeds the sticky bit
  always_comb begin
    quo = '0;
    rem = 26'h0800000;
    for (int i = 24; i >= 0; i--) begin
      rem = {rem[24:0], 1'b0};
      if (rem >= {2'b00, mant}) begin
        rem    = rem - {2'b00, mant};
        quo[i] = 1'b1;
      end
    end
  end

  logic        sticky;
  logic        round_up;
  logic [24:0] mant_rnd;
  logic        carry;
  logic [9:0]  exp_div;
  logic        flush_div;
  logic [22:0] frac_div;
  logic [7:0]  exp_p2;

  assign sticky    = |rem;
  assign round_up  = quo[0] & (sticky | quo[1]);
  assign mant_rnd  = {1'b0, quo[24:1]} + {24'b0, round_up};
  assign carry     = mant_rnd[24];
  assign frac_div  = carry ? 23'b0 : mant_rnd[22:0];
  // Wraps negative (bit 9 set) when the exponent would go below zero
  assign exp_div   = 10'd253 - {2'b00, exp_in} + {9'b0, carry};
  assign flush_div = exp_div[9] | (exp_div == 10'd0);
  assign exp_p2    = 8'd254 - exp_in;

  logic [31:0] res_calc;
  logic        dbz_calc;

  // Special-case decode and selection of the next result
  always_comb begin
    res_calc = {sgn, 31'b0};
    dbz_calc = 1'b0;
    if (exp_in == 8'hFF) begin
      if (frac != 23'b0) res_calc = 32'h7FC00000;
      else               res_calc = {sgn, 31'b0};
    end else if (exp_in == 8'h00) begin
      res_calc = {sgn, 8'hFF, 23'b0};
      dbz_calc = 1'b1;
    end else if (frac == 23'b0) begin
      if (exp_p2 != 8'd0) res_calc = {sgn, exp_p2, 23'b0};
    end else if (!flush_div) begin
      res_calc = {sgn, exp_div[7:0], frac_div};
    end
  end

  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic             dbz_q;

  // Output registers: synchronous reset; result and flag update only on valid operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q <= res_calc;
        dbz_q    <= dbz_calc;
      end
    end
  end

  assign result      = result_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fpu_32_reciprocal.sv
// Scoreboard bench for fpu_32_reciprocal.
// The stimulus process pushes expected responses into a queue.
// A negedge monitor pops one entry and compares whenever out_valid is high.
module tb_fpu_32_reciprocal;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        vin;
  logic [31:0] result;
  logic        out_valid;
  logic        div_by_zero;

  int tests;
  int fails;
  logic [32:0] exp_q[$];
  bit          done;

  fpu_32_reciprocal #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (din),
    .in_valid   (vin),
    .result     (result),
    .out_valid  (out_valid),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] r, input logic z);
    din = x;
    vin = 1'b1;
    exp_q.push_back({r, z});
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares every presented result
  always @(negedge clk) begin
    if (!done && out_valid === 1'b1) begin
      logic [32:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h/%b want none", result, div_by_zero);
      end else begin
        e = exp_q.pop_front();
        if (result !== e[32:1] || div_by_zero !== e[0]) begin
          fails++;
          $display("FAIL result: got %h dbz %b want %h dbz %b", result, div_by_zero,
                   e[32:1], e[0]);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    done  = 1'b0;
    rst_n = 1'b0;
    vin   = 1'b0;
    din   = 32'h40000000;

    // Stream, rounding, specials, flush and a few extra points
    vecs.push_back('{32'h40000000, 32'h3F000000, 1'b0});
    vecs.push_back('{32'h3E800000, 32'h40800000, 1'b0});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0});
    vecs.push_back('{32'h3F000000, 32'h40000000, 1'b0});
    vecs.push_back('{32'h40800000, 32'h3E800000, 1'b0});
    vecs.push_back('{32'h41200000, 32'h3DCCCCCD, 1'b0});
    vecs.push_back('{32'h40400000, 32'h3EAAAAAB, 1'b0});
    vecs.push_back('{32'hC0400000, 32'hBEAAAAAB, 1'b0});
    vecs.push_back('{32'h3FC00000, 32'h3F2AAAAB, 1'b0});
    vecs.push_back('{32'h00000000, 32'h7F800000, 1'b1});
    vecs.push_back('{32'h80000001, 32'hFF800000, 1'b1});
    vecs.push_back('{32'hFF800000, 32'h80000000, 1'b0});
    vecs.push_back('{32'h7F800000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h7FC12345, 32'h7FC00000, 1'b0});
    vecs.push_back('{32'hFFC00000, 32'h7FC00000, 1'b0});
    vecs.push_back('{32'h7F000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h7E800000, 32'h00800000, 1'b0});
    vecs.push_back('{32'h7E800001, 32'h00000000, 1'b0});
    vecs.push_back('{32'hFF7FFFFF, 32'h80000000, 1'b0});
    vecs.push_back('{32'hC1200000, 32'hBDCCCCCD, 1'b0});

    // Reset held for two cycles, with a valid operand present to show it is ignored
    vin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 32'h00000000);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    vin   = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) issue(vecs[i].x, vecs[i].r, vecs[i].z);

    // Hold: in changes while in_valid is low
    vin = 1'b0;
    din = 32'h00000000;
    @(posedge clk);
    #1;
    check("hold_out_valid", {31'b0, out_valid}, 32'd0);
    check("hold_result", result, 32'hBDCCCCCD);
    din = 32'h40400000;
    @(posedge clk);
    #1;
    check("hold_result2", result, 32'hBDCCCCCD);
    check("hold_dbz", {31'b0, div_by_zero}, 32'd0);

    // Load a dbz result, then reset coincident with a valid operand
    issue(32'h80000000, 32'hFF800000, 1'b1);
    rst_n = 1'b0;
    vin   = 1'b1;
    din   = 32'h40000000;
    @(posedge clk);
    #1;
    check("sync_reset_result", result, 32'h00000000);
    check("sync_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("sync_reset_dbz", {31'b0, div_by_zero}, 32'd0);

    // First valid operand after reset is released
    rst_n = 1'b1;
    issue(32'h40000000, 32'h3F000000, 1'b0);
    vin = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
